// File: rtl/icache_ctrl_if.sv
// Datapath and memory-side signals of the direct-mapped instruction cache.
// slave is the cache's view; master is the datapath plus memory model.
interface icache_ctrl_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with one-word frames.
// Hits are combinational in IDLE; misses refill through a single FETCH state.
module icache_ctrl #(
  parameter int unsigned SETS = 16
) (
  input logic         CLK,
  input logic         RST,
  icache_ctrl_if.slave bus
);

  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = 30 - IdxW;

  typedef enum logic [0:0] {StIdle, StFetch} state_t;

  state_t            state_q, state_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic [SETS-1:0]   valid_q;
  logic [TagW-1:0]   tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IdxW-1:0]   req_idx, miss_idx;
  logic [TagW-1:0]   req_tag, miss_tag;
  logic              fill, flush_now;
  logic              ihit, iren;
  logic [31:0]       imemload, iaddr;

  assign req_idx  = bus.imemaddr[IdxW+1:2];
  assign req_tag  = bus.imemaddr[31:IdxW+2];
  assign miss_idx = miss_addr_q[IdxW+1:2];
  assign miss_tag = miss_addr_q[31:IdxW+2];

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = '0;
    iren        = 1'b0;
    iaddr       = bus.imemaddr;
    fill        = 1'b0;
    flush_now   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A flush cycle neither hits nor starts a refill.
        if (bus.flush) begin
          flush_now = 1'b1;
        end else if (bus.imemREN) begin
          if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
            ihit     = 1'b1;
            imemload = data_q[req_idx];
          end else begin
            miss_addr_d = bus.imemaddr;
            state_d     = StFetch;
          end
        end
      end
      StFetch: begin
        iren  = 1'b1;
        iaddr = miss_addr_q;
        if (!bus.iwait) begin
          fill    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (flush_now) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid_q gates every use of them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= bus.iload;
    end
  end

  assign bus.ihit     = ihit;
  assign bus.imemload = imemload;
  assign bus.iREN     = iren;
  assign bus.iaddr    = iaddr;

endmodule
